// File: rtl/rr_priority_arb.sv
// Round-robin arbiter: rotating-pointer search over N request lines, registered grant with valid/ready.
// Latency: request seen in an idle cycle gives a valid grant on the next cycle; one grant per cycle when ready stays high.
// Backpressure: with ready low the grant is frozen (never withdrawn); the pointer advances only on valid & ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (discards any pending grant)
//   req[N]     level-sensitive request vector, bit i = requester i
//   ready      downstream accepts the current grant this cycle
//   valid      grant_idx/grant_oh carry a valid grant
//   grant_idx  index of the granted requester
//   grant_oh   one-hot of grant_idx, all-zero when valid is low
//   none       the last selection cycle found no request
module rr_priority_arb #(
  parameter int N = 8,
  parameter int K = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [K-1:0] grant_idx,
  output logic [N-1:0] grant_oh,
  output logic         none
);

  logic [K-1:0] ptr;
  logic [K-1:0] start;
  logic [N-1:0] masked;
  logic [K-1:0] idx_masked;
  logic [K-1:0] idx_all;
  logic [K-1:0] sel_idx;
  logic         sel_found;

  logic [K-1:0] ptr_nxt;
  logic         valid_nxt;
  logic [K-1:0] idx_nxt;
  logic [N-1:0] oh_nxt;
  logic         none_nxt;

  // Lowest-index-first priority encoder; the descending loop lets the
  // lowest set bit overwrite any higher one.
  function automatic logic [K-1:0] pri_enc(input logic [N-1:0] v);
    logic [K-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = K'(i);
      end
    end
    return idx;
  endfunction

  // Search start: the stored pointer while idle, otherwise the slot after
  // the grant being accepted. The K-bit add wraps N-1 to 0 naturally.
  // When valid & !ready the selection result is unused.
  assign start = valid ? grant_idx + K'(1) : ptr;

  // Keep only requesters at or above the start position; if none remain,
  // fall back to the full vector, which wraps the search below the start.
  assign masked     = req & ({N{1'b1}} << start);
  assign idx_masked = pri_enc(masked);
  assign idx_all    = pri_enc(req);
  assign sel_found  = |req;
  assign sel_idx    = (|masked) ? idx_masked : idx_all;

  always_comb begin
    ptr_nxt   = ptr;
    valid_nxt = valid;
    idx_nxt   = grant_idx;
    oh_nxt    = grant_oh;
    none_nxt  = none;
    // A selection happens when idle or when the current grant is accepted;
    // otherwise everything holds.
    if (!valid || ready) begin
      if (valid) begin
        ptr_nxt = start;
      end
      if (sel_found) begin
        valid_nxt = 1'b1;
        idx_nxt   = sel_idx;
        oh_nxt    = {{(N-1){1'b0}}, 1'b1} << sel_idx;
        none_nxt  = 1'b0;
      end else begin
        valid_nxt = 1'b0;
        oh_nxt    = '0;
        none_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      valid     <= 1'b0;
      grant_idx <= '0;
      grant_oh  <= '0;
      none      <= 1'b1;
    end else begin
      ptr       <= ptr_nxt;
      valid     <= valid_nxt;
      grant_idx <= idx_nxt;
      grant_oh  <= oh_nxt;
      none      <= none_nxt;
    end
  end

endmodule

// File: tb/tb_rr_priority_arb.sv
// Bench for rr_priority_arb: directed vector table on N=8, then a random run on N=2, 8 and 32.
// Latency: outputs are compared 1 time unit after each rising edge, inputs change at the same point.
// Backpressure: random ready exercises grant hold; a reference model and a wait-bound tracker judge results.
module tb_rr_priority_arb;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]  req2;   logic rdy2;  logic v2;  logic [0:0] i2;  logic [1:0]  o2;  logic n2;
  logic [7:0]  req8;   logic rdy8;  logic v8;  logic [2:0] i8;  logic [7:0]  o8;  logic n8;
  logic [31:0] req32;  logic rdy32; logic v32; logic [4:0] i32; logic [31:0] o32; logic n32;

  always #5 clk = ~clk;

  rr_priority_arb #(.N(2), .K(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .ready(rdy2),
    .valid(v2), .grant_idx(i2), .grant_oh(o2), .none(n2));
  rr_priority_arb #(.N(8), .K(3)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .ready(rdy8),
    .valid(v8), .grant_idx(i8), .grant_oh(o8), .none(n8));
  rr_priority_arb #(.N(32), .K(5)) dut32 (
    .clk(clk), .rst(rst), .req(req32), .ready(rdy32),
    .valid(v32), .grant_idx(i32), .grant_oh(o32), .none(n32));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // ---------------- directed table (N=8) ----------------
  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       v;
    logic [2:0] idx;
    logic       idx_care;
    logic [7:0] oh;
    logic       none;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] q, input logic rd, input logic v,
                     input logic [2:0] ix, input logic care, input logic [7:0] oh, input logic nn);
    vec_t e;
    e.rst = r; e.req = q; e.rdy = rd; e.v = v;
    e.idx = ix; e.idx_care = care; e.oh = oh; e.none = nn;
    tbl.push_back(e);
  endtask

  // ---------------- reference model (generic up to 32) ----------------
  bit mv[3];
  bit mn[3];
  int mi[3];
  int mp[3];
  int waits[3][32];

  function automatic int sel(input logic [31:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic mreset(input int x);
    mv[x] = 1'b0; mn[x] = 1'b1; mi[x] = 0; mp[x] = 0;
  endtask

  task automatic mstep(input int x, input int n, input logic [31:0] r, input logic rdy);
    int s;
    if (!mv[x]) begin
      s = sel(r, mp[x], n);
      if (s >= 0) begin
        mv[x] = 1'b1; mi[x] = s; mn[x] = 1'b0;
      end else begin
        mn[x] = 1'b1;
      end
    end else if (rdy) begin
      mp[x] = (mi[x] + 1) % n;
      s = sel(r, mp[x], n);
      if (s >= 0) begin
        mi[x] = s; mn[x] = 1'b0;
      end else begin
        mv[x] = 1'b0; mn[x] = 1'b1;
      end
    end
  endtask

  // Starvation tracker driven by the observed DUT handshakes, not by the model.
  task automatic track(input int x, input int n, input logic [31:0] r, input logic rs,
                       input logic rdy, input logic v, input int idx);
    for (int j = 0; j < n; j++) begin
      if (rs || !r[j]) begin
        waits[x][j] = 0;
      end else if (v && rdy) begin
        if (j == idx) begin
          waits[x][j] = 0;
        end else begin
          waits[x][j]++;
          checks++;
          if (waits[x][j] > n - 1) begin
            errors++;
            $display("FAIL wait_bound n=%0d req%0d waited %0d handshakes, limit %0d",
                     n, j, waits[x][j], n - 1);
          end
        end
      end
    end
  endtask

  task automatic cmp(input int x, input int c, input logic v, input logic nn,
                     input int idx, input logic [31:0] oh);
    logic [63:0] act;
    logic [63:0] exp;
    logic [31:0] eoh;
    eoh = mv[x] ? (32'h1 << mi[x]) : 32'h0;
    act = {22'h0, v, nn, (mv[x] ? 8'(idx) : 8'h0), oh};
    exp = {22'h0, mv[x], mn[x], (mv[x] ? 8'(mi[x]) : 8'h0), eoh};
    chk($sformatf("rand inst%0d cyc%0d", x, c), act, exp);
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] r, input int n);
    logic [31:0] q;
    q = r;
    case ($urandom_range(7))
      0:       q = $urandom;
      1:       q = '0;
      2, 3:    q = q ^ (32'h1 << $urandom_range(n - 1));
      default: q = r;
    endcase
    if (n < 32) q = q & ((32'h1 << n) - 32'h1);
    return q;
  endfunction

  initial begin
    logic [31:0] r2, r8, r32;

    rst = 1'b1;
    req2 = '0; rdy2 = 1'b0;
    req8 = '0; rdy8 = 1'b0;
    req32 = '0; rdy32 = 1'b0;

    // reset with requests present, then idle
    add(1, 8'hFF, 0, 0, 3'd0, 1, 8'h00, 1);
    add(1, 8'hFF, 0, 0, 3'd0, 1, 8'h00, 1);
    add(0, 8'h00, 0, 0, 3'd0, 1, 8'h00, 1);
    add(0, 8'h00, 1, 0, 3'd0, 1, 8'h00, 1);
    // rotation over bits 2,5,7 with ready high
    add(0, 8'hA4, 1, 1, 3'd2, 1, 8'h04, 0);
    add(0, 8'hA4, 1, 1, 3'd5, 1, 8'h20, 0);
    add(0, 8'hA4, 1, 1, 3'd7, 1, 8'h80, 0);
    add(0, 8'hA4, 1, 1, 3'd2, 1, 8'h04, 0);
    add(0, 8'hA4, 1, 1, 3'd5, 1, 8'h20, 0);
    // accept 5 with nothing pending: idle, pointer now 6
    add(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 1);
    // single request below the pointer wraps to 4, held 5 cycles under ready=0
    for (int k = 0; k < 5; k++) add(0, 8'h10, 0, 1, 3'd4, 1, 8'h10, 0);
    // request drops while granted: grant is not withdrawn
    add(0, 8'h00, 0, 1, 3'd4, 1, 8'h10, 0);
    // accepted with nothing pending
    add(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 1);
    // pointer at 5: 5 wins over 0, then 0
    add(0, 8'h21, 0, 1, 3'd5, 1, 8'h20, 0);
    add(0, 8'h21, 1, 1, 3'd0, 1, 8'h01, 0);
    add(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 1);
    // full load after reset: 0..7 twice, no skips
    add(1, 8'h00, 0, 0, 3'd0, 1, 8'h00, 1);
    for (int k = 0; k < 16; k++) add(0, 8'hFF, 1, 1, 3'(k % 8), 1, 8'h01 << (k % 8), 0);
    // keep going until idx 5, then reset mid-operation
    for (int k = 0; k < 6; k++) add(0, 8'hFF, 1, 1, 3'(k), 1, 8'h01 << k, 0);
    add(1, 8'hFF, 1, 0, 3'd0, 1, 8'h00, 1);
    add(0, 8'hFF, 1, 1, 3'd0, 1, 8'h01, 0);
    add(0, 8'hFF, 1, 1, 3'd1, 1, 8'h02, 0);

    @(negedge clk);
    foreach (tbl[r]) begin
      logic [2:0] ai;
      logic [2:0] ei;
      rst  = tbl[r].rst;
      req8 = tbl[r].req;
      rdy8 = tbl[r].rdy;
      @(posedge clk);
      #1;
      ai = tbl[r].idx_care ? i8 : 3'd0;
      ei = tbl[r].idx_care ? tbl[r].idx : 3'd0;
      chk($sformatf("vec%0d", r), {51'h0, v8, n8, ai, o8},
          {51'h0, tbl[r].v, tbl[r].none, ei, tbl[r].oh});
    end

    // ---------------- random run on all three widths ----------------
    r2 = '0; r8 = '0; r32 = '0;
    for (int c = 0; c < 10000; c++) begin
      rst = (c < 2);
      r2  = nxt(r2, 2);
      r8  = nxt(r8, 8);
      r32 = nxt(r32, 32);
      req2  = r2[1:0];
      req8  = r8[7:0];
      req32 = r32;
      rdy2  = ($urandom_range(3) != 0);
      rdy8  = ($urandom_range(3) != 0);
      rdy32 = ($urandom_range(3) != 0);

      track(0, 2,  r2,  rst, rdy2,  v2,  int'(i2));
      track(1, 8,  r8,  rst, rdy8,  v8,  int'(i8));
      track(2, 32, r32, rst, rdy32, v32, int'(i32));

      if (rst) begin
        mreset(0); mreset(1); mreset(2);
      end else begin
        mstep(0, 2,  r2,  rdy2);
        mstep(1, 8,  r8,  rdy8);
        mstep(2, 32, r32, rdy32);
      end

      @(posedge clk);
      #1;
      cmp(0, c, v2,  n2,  int'(i2),  32'(o2));
      cmp(1, c, v8,  n8,  int'(i8),  32'(o8));
      cmp(2, c, v32, n32, int'(i32), o32);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
